// File: rtl/alu_multicycle.sv
// Execution-stage ALU with start/done handshake: single-cycle logic/arith ops,
// iterative shift-add MULTU and restoring DIVU writing HI/LO.
module alu_multicycle #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic                  div_by_zero_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q;
  logic [3:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] work_hi_q;  // MULTU partial-product high half / DIVU remainder
  logic [DATA_WIDTH-1:0] work_lo_q;  // MULTU multiplier shifter / DIVU quotient shifter
  logic [CNT_W-1:0]      count_q;

  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH-1:0] mul_hi_next;
  logic [DATA_WIDTH-1:0] mul_lo_next;
  logic [DATA_WIDTH:0]   div_shift;
  logic [DATA_WIDTH:0]   div_diff;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] div_hi_next;
  logic [DATA_WIDTH-1:0] div_lo_next;
  logic [DATA_WIDTH-1:0] simple_result;

  // NOTE: every always_comb output gets a value on every path (defaults first),
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    mul_sum     = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, a_q} : '0);
    mul_hi_next = mul_sum[DATA_WIDTH:1];
    mul_lo_next = {mul_sum[0], work_lo_q[DATA_WIDTH-1:1]};

    // Remainder stays below b, so bit DATA_WIDTH of the difference is the borrow.
    div_shift   = {work_hi_q, work_lo_q[DATA_WIDTH-1]};
    div_diff    = div_shift - {1'b0, b_q};
    div_ge      = ~div_diff[DATA_WIDTH];
    div_hi_next = div_ge ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
    div_lo_next = {work_lo_q[DATA_WIDTH-2:0], div_ge};

    simple_result = '0;
    case (op_q)
      OP_AND: simple_result = a_q & b_q;
      OP_OR:  simple_result = a_q | b_q;
      OP_ADD: simple_result = a_q + b_q;
      OP_SUB: simple_result = a_q - b_q;
      OP_SLT: simple_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: simple_result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      work_hi_q     <= '0;
      work_lo_q     <= '0;
      count_q       <= '0;
      result_o      <= '0;
      zero_o        <= 1'b1;
      hi_o          <= '0;
      lo_o          <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            op_q      <= alu_operation_i;
            a_q       <= a_i;
            b_q       <= b_i;
            work_hi_q <= '0;
            work_lo_q <= (alu_operation_i == OP_DIVU) ? a_i : b_i;
            count_q   <= CNT_W'(DATA_WIDTH);
            state_q   <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (op_q == OP_DIVU && b_q == '0) begin
            lo_o          <= '1;
            hi_o          <= a_q;
            result_o      <= '1;
            zero_o        <= 1'b0;
            div_by_zero_o <= 1'b1;
            state_q       <= ST_DONE;
          end else if (op_q == OP_MULTU || op_q == OP_DIVU) begin
            work_hi_q <= (op_q == OP_MULTU) ? mul_hi_next : div_hi_next;
            work_lo_q <= (op_q == OP_MULTU) ? mul_lo_next : div_lo_next;
            count_q   <= count_q - 1'b1;
            if (count_q == CNT_W'(1)) begin
              hi_o          <= (op_q == OP_MULTU) ? mul_hi_next : div_hi_next;
              lo_o          <= (op_q == OP_MULTU) ? mul_lo_next : div_lo_next;
              result_o      <= (op_q == OP_MULTU) ? mul_lo_next : div_lo_next;
              zero_o        <= ((op_q == OP_MULTU) ? mul_lo_next : div_lo_next) == '0;
              div_by_zero_o <= 1'b0;
              state_q       <= ST_DONE;
            end
          end else begin
            result_o      <= simple_result;
            zero_o        <= (simple_result == '0);
            div_by_zero_o <= 1'b0;
            state_q       <= ST_DONE;
          end
        end

        ST_DONE: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);

endmodule
